// File: rtl/systolic_job_sequencer.sv
// Job sequencer for the systolic-array peripheral: takes one job descriptor,
// streams weights and inputs into the load ports, triggers inference and
// buffers the results in a small FIFO.
// Optional build macro TIMEOUT_EN adds a watchdog on the wait states (code 100).
module systolic_job_sequencer #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned MAX_BATCH = 64,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [$clog2(MAX_BATCH):0]  job_batch,
  input  logic [1:0]                  job_act_mode,
  input  logic                        job_reuse_w,
  input  logic                        wdata_valid,
  output logic                        wdata_ready,
  input  logic [63:0]                 wdata,
  input  logic                        idata_valid,
  output logic                        idata_ready,
  input  logic [63:0]                 idata,
  output logic                        load_weights,
  output logic                        load_weights_en,
  output logic                        load_inputs_en,
  output logic                        start_inference,
  output logic [63:0]                 weight_reg,
  output logic [63:0]                 input_reg,
  output logic [1:0]                  activation_mode,
  input  logic                        controller_busy,
  input  logic                        weights_done,
  input  logic                        inputs_done,
  input  logic                        data_ready,
  input  logic                        occupancy_err,
  input  logic                        systolic_done,
  input  logic [63:0]                 output_reg,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [63:0]                 res_data,
  output logic                        busy,
  output logic                        job_done,
  output logic                        err,
  output logic [2:0]                  err_code,
  input  logic                        err_clr
);

  localparam int unsigned CntW = $clog2(MAX_BATCH) + 1;
  localparam int unsigned AW   = $clog2(RES_DEPTH);
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [AW:0]     PtrOne = 1;

  typedef enum logic [2:0] {StIdle, StWLoad, StWWait, StILoad, StRun, StDone, StError} state_e;

  state_e state_q, state_d;
  logic [2:0]      err_code_q, err_code_d;
  logic [CntW-1:0] batch_q, cnt_q, out_cnt_q;
  logic [1:0]      act_q;
  logic            wres_q, in_seen_q, sys_seen_q;
  logic            load_weights_q, start_q, lw_en_q, li_en_q;
  logic [63:0]     weight_q, input_q;
  logic [63:0]     mem_q [RES_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;

  logic w_hs, i_hs, empty, full, push, pop, do_push, overflow, tmo_hit;

  assign w_hs     = wdata_valid & wdata_ready;
  assign i_hs     = idata_valid & idata_ready;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = !empty & res_ready;
  assign push     = (state_q == StRun) & data_ready;
  // A push into a full FIFO is fine only when a pop frees a slot the same cycle
  assign do_push  = push & (!full | pop);
  assign overflow = push & full & !pop;

`ifdef TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_active;
  assign tmo_active = (state_q == StWWait) || (state_q == StRun) ||
                      ((state_q == StILoad) && (cnt_q == batch_q));
  assign tmo_hit    = tmo_active && (tmo_q == TW'(TIMEOUT - 1));

  // Watchdog restarts on every state change and on every result word
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) tmo_q <= '0;
    else if (!tmo_active || (state_d != state_q) || data_ready) tmo_q <= '0;
    else tmo_q <= tmo_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State and error-code register
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= StIdle;
      err_code_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic; error sources override the normal flow with fixed priority
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (job_valid) begin
          if ((job_batch == '0) || (job_batch > CntW'(MAX_BATCH))) begin
            state_d    = StError;
            err_code_d = 3'b001;
          end else if (job_reuse_w && wres_q) begin
            state_d = StILoad;
          end else begin
            state_d = StWLoad;
          end
        end
      end
      StWLoad: if (w_hs && (cnt_q == CntW'(ROWS - 1))) state_d = StWWait;
      StWWait: if (weights_done) state_d = StILoad;
      StILoad: if ((cnt_q == batch_q) && (in_seen_q || inputs_done)) state_d = StRun;
      StRun:   if ((out_cnt_q == batch_q) && (sys_seen_q || systolic_done)) state_d = StDone;
      StDone:  state_d = StIdle;
      StError: begin
        if (err_clr) begin
          state_d    = StIdle;
          err_code_d = 3'b000;
        end
      end
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && (state_q != StError)) begin
      if (occupancy_err) begin
        state_d    = StError;
        err_code_d = 3'b010;
      end else if (overflow) begin
        state_d    = StError;
        err_code_d = 3'b011;
      end else if (tmo_hit) begin
        state_d    = StError;
        err_code_d = 3'b100;
      end
    end
  end

  // Job latches, stream counters, sticky status and registered strobes
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      batch_q        <= '0;
      act_q          <= '0;
      wres_q         <= 1'b0;
      cnt_q          <= '0;
      out_cnt_q      <= '0;
      in_seen_q      <= 1'b0;
      sys_seen_q     <= 1'b0;
      load_weights_q <= 1'b0;
      start_q        <= 1'b0;
      lw_en_q        <= 1'b0;
      li_en_q        <= 1'b0;
      weight_q       <= '0;
      input_q        <= '0;
    end else begin
      if (job_valid && (state_q == StIdle)) begin
        batch_q <= job_batch;
        act_q   <= job_act_mode;
      end
      if (state_d == StError) wres_q <= 1'b0;
      else if ((state_q == StIdle) && (state_d == StWLoad)) wres_q <= 1'b0;
      else if ((state_q == StWWait) && (state_d == StILoad)) wres_q <= 1'b1;
      if (state_d != state_q) cnt_q <= '0;
      else if ((w_hs || i_hs) && (cnt_q < CntW'(MAX_BATCH))) cnt_q <= cnt_q + CntOne;
      if (state_q != StRun) out_cnt_q <= '0;
      else if (push && (out_cnt_q < CntW'(MAX_BATCH))) out_cnt_q <= out_cnt_q + CntOne;
      in_seen_q      <= (state_q == StILoad) && (in_seen_q || inputs_done);
      sys_seen_q     <= (state_q == StRun) && (sys_seen_q || systolic_done);
      load_weights_q <= (state_q == StIdle) && (state_d == StWLoad);
      start_q        <= (state_q == StILoad) && (state_d == StRun);
      lw_en_q        <= w_hs;
      li_en_q        <= i_hs;
      if (w_hs) weight_q <= wdata;
      if (i_hs) input_q <= idata;
    end
  end

  // Result FIFO; keeps draining regardless of sequencer state
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= output_reg;
        wr_ptr_q                <= wr_ptr_q + PtrOne;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Outputs; peripheral strobes are forced low while in ERROR
  always_comb begin
    job_ready       = (state_q == StIdle);
    busy            = (state_q != StIdle);
    job_done        = (state_q == StDone);
    err             = (state_q == StError);
    err_code        = err_code_q;
    wdata_ready     = (state_q == StWLoad) && !controller_busy && !load_weights_q &&
                      (cnt_q < CntW'(ROWS));
    idata_ready     = (state_q == StILoad) && !controller_busy && (cnt_q < batch_q);
    load_weights    = load_weights_q && (state_q == StWLoad);
    load_weights_en = lw_en_q && (state_q != StError);
    load_inputs_en  = li_en_q && (state_q != StError);
    start_inference = start_q && (state_q == StRun);
    weight_reg      = weight_q;
    input_reg       = input_q;
    activation_mode = act_q;
    res_valid       = !empty;
    res_data        = mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// Directed bench for systolic_job_sequencer (default build, TIMEOUT_EN undefined).
module tb_systolic_job_sequencer;

  logic        clk, n_rst;
  logic        job_valid, job_ready, job_reuse_w;
  logic [6:0]  job_batch;
  logic [1:0]  job_act_mode, activation_mode;
  logic        wdata_valid, wdata_ready, idata_valid, idata_ready;
  logic [63:0] wdata, idata, weight_reg, input_reg, output_reg, res_data;
  logic        load_weights, load_weights_en, load_inputs_en, start_inference;
  logic        controller_busy, weights_done, inputs_done, data_ready, occupancy_err;
  logic        systolic_done, res_valid, res_ready, busy, job_done, err, err_clr;
  logic [2:0]  err_code;

  int tests = 0;
  int fails = 0;
  int n_lw = 0, n_lwe = 0, n_lie = 0, n_st = 0, n_jd = 0;
  int b_lw, b_lwe, b_lie, b_st, b_jd;

  systolic_job_sequencer dut (
    .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_batch(job_batch), .job_act_mode(job_act_mode), .job_reuse_w(job_reuse_w),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .idata_valid(idata_valid), .idata_ready(idata_ready), .idata(idata),
    .load_weights(load_weights), .load_weights_en(load_weights_en),
    .load_inputs_en(load_inputs_en), .start_inference(start_inference),
    .weight_reg(weight_reg), .input_reg(input_reg), .activation_mode(activation_mode),
    .controller_busy(controller_busy), .weights_done(weights_done),
    .inputs_done(inputs_done), .data_ready(data_ready), .occupancy_err(occupancy_err),
    .systolic_done(systolic_done), .output_reg(output_reg), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy), .job_done(job_done),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe pulse counters
  always @(posedge clk) begin
    if (load_weights)    n_lw++;
    if (load_weights_en) n_lwe++;
    if (load_inputs_en)  n_lie++;
    if (start_inference) n_st++;
    if (job_done)        n_jd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_lw = n_lw; b_lwe = n_lwe; b_lie = n_lie; b_st = n_st; b_jd = n_jd;
  endtask

  task automatic give_job(input logic [6:0] b, input logic r);
    job_valid = 1'b1; job_batch = b; job_reuse_w = r;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] v);
    int n = 0;
    wdata = v; wdata_valid = 1'b1;
    while (!wdata_ready && n < 20) begin tick(); n++; end
    chk("wdata_ready", {63'd0, wdata_ready}, 64'd1);
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic send_i(input logic [63:0] v);
    int n = 0;
    idata = v; idata_valid = 1'b1;
    while (!idata_ready && n < 20) begin tick(); n++; end
    chk("idata_ready", {63'd0, idata_ready}, 64'd1);
    tick();
    idata_valid = 1'b0;
  endtask

  task automatic load_all_weights();
    for (int k = 1; k <= 8; k++) send_w(64'(k));
    tick();
    weights_done = 1'b1; tick(); weights_done = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1; job_valid = 0; job_batch = 0; job_act_mode = 0; job_reuse_w = 0;
    wdata_valid = 0; wdata = 0; idata_valid = 0; idata = 0; controller_busy = 0;
    weights_done = 0; inputs_done = 0; data_ready = 0; occupancy_err = 0;
    systolic_done = 0; output_reg = 0; res_ready = 0; err_clr = 0;
    tick(); tick();
    n_rst = 1'b0;
    tick();
    chk("rst job_ready", {63'd0, job_ready}, 64'd1);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst err", {63'd0, err}, 64'd0);
    chk("rst err_code", {61'd0, err_code}, 64'd0);
    chk("rst res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst load_weights", {63'd0, load_weights}, 64'd0);

    // Job 1: batch 2, fresh weights
    snap();
    job_act_mode = 2'b10;
    give_job(7'd2, 1'b0);
    chk("j1 load_weights", {63'd0, load_weights}, 64'd1);
    chk("j1 act_mode", {62'd0, activation_mode}, 64'd2);
    chk("j1 wready on entry", {63'd0, wdata_ready}, 64'd0);
    for (int k = 1; k <= 8; k++) send_w(64'(k));
    tick();
    chk("j1 weight_reg", weight_reg, 64'h8);
    chk("j1 lw pulses", 64'(n_lw - b_lw), 64'd1);
    chk("j1 lwe pulses", 64'(n_lwe - b_lwe), 64'd8);
    weights_done = 1'b1; tick(); weights_done = 1'b0;
    send_i(64'h11);
    send_i(64'h22);
    inputs_done = 1'b1; tick(); inputs_done = 1'b0;
    chk("j1 start_inference", {63'd0, start_inference}, 64'd1);
    chk("j1 input_reg", input_reg, 64'h22);
    chk("j1 lie pulses", 64'(n_lie - b_lie), 64'd2);
    data_ready = 1'b1; output_reg = 64'hAA; tick();
    output_reg = 64'hBB; tick();
    data_ready = 1'b0; systolic_done = 1'b1; tick(); systolic_done = 1'b0;
    chk("j1 job_done", {63'd0, job_done}, 64'd1);
    tick();
    chk("j1 job_done width", {63'd0, job_done}, 64'd0);
    chk("j1 job_ready", {63'd0, job_ready}, 64'd1);
    chk("j1 st pulses", 64'(n_st - b_st), 64'd1);
    chk("j1 res first", res_data, 64'hAA);
    res_ready = 1'b1; tick();
    chk("j1 res second", res_data, 64'hBB);
    tick(); res_ready = 1'b0;
    chk("j1 fifo empty", {63'd0, res_valid}, 64'd0);

    // Job 2: reuse resident weights, batch 1
    snap();
    give_job(7'd1, 1'b1);
    chk("j2 no load_weights", {63'd0, load_weights}, 64'd0);
    send_i(64'h33);
    inputs_done = 1'b1; tick(); inputs_done = 1'b0;
    data_ready = 1'b1; systolic_done = 1'b1; output_reg = 64'hCC; tick();
    data_ready = 1'b0; systolic_done = 1'b0; tick();
    chk("j2 job_done", {63'd0, job_done}, 64'd1);
    chk("j2 lw pulses", 64'(n_lw - b_lw), 64'd0);
    chk("j2 lwe pulses", 64'(n_lwe - b_lwe), 64'd0);
    chk("j2 lie pulses", 64'(n_lie - b_lie), 64'd1);
    chk("j2 res", res_data, 64'hCC);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // Job 3: batch 0 rejected
    snap();
    give_job(7'd0, 1'b0);
    chk("j3 err", {63'd0, err}, 64'd1);
    chk("j3 err_code", {61'd0, err_code}, 64'd1);
    chk("j3 job_ready", {63'd0, job_ready}, 64'd0);
    tick();
    chk("j3 no strobes", 64'(n_lw - b_lw + n_lwe - b_lwe + n_lie - b_lie + n_st - b_st), 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("j3 cleared ready", {63'd0, job_ready}, 64'd1);
    chk("j3 cleared code", {61'd0, err_code}, 64'd0);

    // Job 4: result overflow with res_ready held low
    give_job(7'd5, 1'b0);
    load_all_weights();
    for (int k = 0; k < 5; k++) send_i(64'(k));
    inputs_done = 1'b1; tick(); inputs_done = 1'b0;
    data_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin output_reg = 64'h100 + 64'(k); tick(); end
    data_ready = 1'b0;
    chk("j4 err", {63'd0, err}, 64'd1);
    chk("j4 err_code", {61'd0, err_code}, 64'd3);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("j4 drain valid", {63'd0, res_valid}, 64'd1);
      chk("j4 drain data", res_data, 64'h100 + 64'(k));
      tick();
    end
    res_ready = 1'b0;
    chk("j4 drained", {63'd0, res_valid}, 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Job 5: occupancy error during input load
    give_job(7'd2, 1'b0);
    load_all_weights();
    send_i(64'h55);
    occupancy_err = 1'b1; tick(); occupancy_err = 1'b0;
    chk("j5 err", {63'd0, err}, 64'd1);
    chk("j5 err_code", {61'd0, err_code}, 64'd2);
    chk("j5 idata_ready", {63'd0, idata_ready}, 64'd0);
    chk("j5 lie gated", {63'd0, load_inputs_en}, 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Job 6: reuse requested but weights were invalidated by the error
    give_job(7'd1, 1'b1);
    chk("j6 reload weights", {63'd0, load_weights}, 64'd1);
    chk("j6 busy", {63'd0, busy}, 64'd1);

    // Asynchronous reset mid-job
    #2 n_rst = 1'b1; #1;
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst job_ready", {63'd0, job_ready}, 64'd1);
    chk("midrst load_weights", {63'd0, load_weights}, 64'd0);
    tick();
    n_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
